// File: rtl/muacm_in_arb_pkg.sv
// Shared constants for the muacm IN-stream arbiter: state encoding, tag base
// byte and counter width.
package muacm_arb_pkg;

  localparam int CNT_W = 8;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TAG  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  function automatic logic [7:0] tag_byte(input int unsigned idx);
    return TAG_BASE | 8'(idx);
  endfunction

endpackage

// File: rtl/muacm_in_arb_if.sv
// Requester-side and muacm-side IN stream signals of the arbiter.
// slave: the arbiter; master: the requesters plus the muacm core.
interface muacm_in_arb_if #(
  parameter int N_PORTS = 2
);
  logic [8*N_PORTS-1:0] req_data;
  logic [N_PORTS-1:0]   req_last;
  logic [N_PORTS-1:0]   req_valid;
  logic [N_PORTS-1:0]   req_ready;
  logic [N_PORTS-1:0]   req_flush;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_flush_now;
  logic                 in_flush_time;
  logic [N_PORTS-1:0]   grant;

  modport slave (
    input  req_data, req_last, req_valid, req_flush, in_ready,
    output req_ready, in_data, in_last, in_valid, in_flush_now, in_flush_time, grant
  );

  modport master (
    output req_data, req_last, req_valid, req_flush, in_ready,
    input  req_ready, in_data, in_last, in_valid, in_flush_now, in_flush_time, grant
  );
endinterface

// File: rtl/muacm_in_arb_rr.sv
// Combinational rotate-priority picker: first set request at or above ptr_i,
// wrapping, returned as one-hot, binary index and an any flag.
module muacm_arb_rr #(
  parameter int N_PORTS = 2,
  parameter int IW      = 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  int unsigned k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      k = (32'(ptr_i) + i) % N_PORTS;
      if (!any_o && req_i[k[IW-1:0]]) begin
        any_o             = 1'b1;
        gnt_o[k[IW-1:0]]  = 1'b1;
        idx_o             = k[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/muacm_in_arb.sv
// Packet-atomic round-robin arbiter in front of the muacm IN stream.
// Define MUACM_ARB_TAG_EN to prefix each grant with a tag byte (A0 | port).
module muacm_in_arb #(
  parameter int N_PORTS   = 2,
  parameter int MAX_BURST = 64,
  parameter int IDLE_TO   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  muacm_in_arb_if.slave bus
);
  import muacm_arb_pkg::*;

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [1:0]         state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic [N_PORTS-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic               g_valid, g_last, g_flush;
  logic [7:0]         g_data;
  logic               xfer, rel;
  logic [CNT_W-1:0]   burst_inc, stall_inc;

  muacm_arb_rr #(
    .N_PORTS (N_PORTS),
    .IW      (IW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign g_valid = bus.req_valid[gidx_q];
  assign g_last  = bus.req_last[gidx_q];
  assign g_flush = bus.req_flush[gidx_q];
  assign g_data  = bus.req_data[{gidx_q, 3'b000} +: 8];

  assign bus.in_flush_time = 1'b1;
  assign bus.grant         = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    burst_d   = burst_q;
    stall_d   = stall_q;
    xfer      = 1'b0;
    rel       = 1'b0;
    burst_inc = burst_q + 1'b1;
    stall_inc = stall_q + 1'b1;

    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.in_valid     = 1'b0;
    bus.req_ready    = '0;
    bus.in_flush_now = |bus.req_flush;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          burst_d = '0;
          stall_d = '0;
`ifdef MUACM_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_DATA;
`endif
        end
      end

      ST_TAG: begin
`ifdef MUACM_ARB_TAG_EN
        bus.in_flush_now = g_flush;
        bus.in_valid     = 1'b1;
        bus.in_data      = tag_byte(int unsigned'(gidx_q));
        if (bus.in_ready) state_d = ST_DATA;
`else
        state_d = ST_IDLE;
        grant_d = '0;
`endif
      end

      ST_DATA: begin
        bus.in_flush_now       = g_flush;
        bus.in_valid           = g_valid;
        bus.req_ready[gidx_q]  = bus.in_ready;
        if (g_valid) begin
          bus.in_data = g_data;
          bus.in_last = g_last;
        end
        xfer    = g_valid & bus.in_ready;
        stall_d = g_valid ? '0 : stall_inc;
        if (xfer) burst_d = burst_inc;
        // All three release causes collapse into one transition back to IDLE.
        rel = (xfer && g_last)
           || (xfer && burst_inc == CNT_W'(MAX_BURST))
           || (!g_valid && stall_inc == CNT_W'(IDLE_TO));
        if (rel) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          burst_d  = '0;
          stall_d  = '0;
          rr_ptr_d = (gidx_q == IW'(N_PORTS - 1)) ? '0 : gidx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
    end
  end
endmodule

// File: tb/tb_muacm_in_arb.sv
// Self-checking bench for muacm_in_arb: per-port byte sources, a scoreboard of
// expected IN-stream bytes with expected idle gaps, and table-driven IDLE checks.
module tb_muacm_in_arb;
  localparam int N   = 3;
  localparam int MB  = 64;
  localparam int ITO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muacm_in_arb_if #(.N_PORTS(N)) bus ();

  muacm_in_arb #(
    .N_PORTS   (N),
    .MAX_BURST (MB),
    .IDLE_TO   (ITO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [7:0] d; logic l; int gap; } src_t;
  typedef struct { int port; logic [7:0] d; logic l; int gap; } exp_t;
  typedef struct { logic [N-1:0] mask; logic [N-1:0] g; } gvec_t;
  typedef struct { logic [N-1:0] f; logic e; } fvec_t;

  src_t         srcq [N][$];
  exp_t         expq [$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           idle_cnt = 0;
  logic [N-1:0] flush_drv = '0;
  int           ready_mode = 0;
  logic [N-1:0] fire = '0;
  bit           loaded [N];
  int           gap_left [N];
  gvec_t        gtab [6];
  fvec_t        ftab [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add_src(input int port, input logic [7:0] d, input logic l, input int gap);
    src_t s;
    s.d = d; s.l = l; s.gap = gap;
    srcq[port].push_back(s);
  endtask

  task automatic add_exp(input int port, input logic [7:0] d, input logic l, input int gap);
    exp_t e;
    e.port = port; e.d = d; e.l = l; e.gap = gap;
    expq.push_back(e);
  endtask

  // Tag byte leads each grant when the feature is built in.
  task automatic exp_grant(input int port, inout int gap);
`ifdef MUACM_ARB_TAG_EN
    logic [7:0] t;
    t = 8'hA0 | 8'(port);
    add_exp(port, t, 1'b0, gap);
    if (gap >= 0) gap = 0;
`endif
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while (expq.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, expq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) srcq[k].delete();
    expq.delete();
    flush_drv  = '0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_valid"}, bus.in_valid, 0);
    chk({tag, "_in_data"},  bus.in_data, 0);
    chk({tag, "_in_last"},  bus.in_last, 0);
    chk({tag, "_grant"},    bus.grant, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_flush_now"}, bus.in_flush_now, 0);
  endtask

  // Requester and muacm-side driver: one process owns every DUT input.
  initial begin
    logic rdy_tog;
    rdy_tog = 1'b0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.req_valid = '0;
    bus.req_flush = '0;
    bus.in_ready  = 1'b1;
    for (int k = 0; k < N; k++) begin loaded[k] = 0; gap_left[k] = 0; end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (fire[k] && srcq[k].size() > 0) begin
          void'(srcq[k].pop_front());
          loaded[k] = 0;
        end
        if (srcq[k].size() > 0) begin
          if (!loaded[k]) begin
            gap_left[k] = srcq[k][0].gap;
            loaded[k]   = 1;
          end
          if (gap_left[k] > 0) begin
            gap_left[k]--;
            bus.req_valid[k]      = 1'b0;
            bus.req_data[8*k +: 8] = '0;
            bus.req_last[k]       = 1'b0;
          end else begin
            bus.req_valid[k]      = 1'b1;
            bus.req_data[8*k +: 8] = srcq[k][0].d;
            bus.req_last[k]       = srcq[k][0].l;
          end
        end else begin
          loaded[k]             = 0;
          bus.req_valid[k]      = 1'b0;
          bus.req_data[8*k +: 8] = '0;
          bus.req_last[k]       = 1'b0;
        end
      end
      bus.req_flush = flush_drv;
      if (ready_mode == 0) bus.in_ready = 1'b1;
      else begin
        rdy_tog      = ~rdy_tog;
        bus.in_ready = rdy_tog;
      end
    end
  end

  // Output monitor: scoreboard pop on every transfer, plus per-cycle invariants.
  always @(negedge clk) begin
    fire = rst_n ? (bus.req_valid & bus.req_ready) : '0;
    if (!rst_n) idle_cnt = 0;
    else begin
      if (bus.in_valid && bus.in_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected: got data %0h grant %0h, nothing expected at %0t",
                   bus.in_data, bus.grant, $time);
        end else begin
          mon_e = expq.pop_front();
          chk("xfer_data", bus.in_data, mon_e.d);
          chk("xfer_last", bus.in_last, mon_e.l);
          chk("xfer_grant", bus.grant, 1 << mon_e.port);
          if (mon_e.gap >= 0) chk("xfer_gap", idle_cnt, mon_e.gap);
        end
        idle_cnt = 0;
      end else idle_cnt++;
      if (bus.grant != 0 && bus.in_valid && bus.in_data < 8'hA0)
        chk("ready_mirror", bus.req_ready, bus.grant & {N{bus.in_ready}});
      if (!bus.in_valid) chk("idle_zero", {bus.in_data, bus.in_last}, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;

    gtab[0] = '{mask: 3'b001, g: 3'b001};
    gtab[1] = '{mask: 3'b010, g: 3'b010};
    gtab[2] = '{mask: 3'b110, g: 3'b010};
    gtab[3] = '{mask: 3'b100, g: 3'b100};
    gtab[4] = '{mask: 3'b111, g: 3'b001};
    gtab[5] = '{mask: 3'b101, g: 3'b001};
    ftab[0] = '{f: 3'b000, e: 1'b0};
    ftab[1] = '{f: 3'b001, e: 1'b1};
    ftab[2] = '{f: 3'b010, e: 1'b1};
    ftab[3] = '{f: 3'b100, e: 1'b1};
    ftab[4] = '{f: 3'b011, e: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("flush_time", bus.in_flush_time, 1);
    rst_n = 1'b1;

    // First grant after reset picks lowest valid port; remaining ports follow in order
    for (int v = 0; v < 6; v++) begin
      do_reset();
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (gtab[v].mask[k]) begin
          add_src(k, 8'h40 + 8'(k), 1'b1, 0);
          exp_grant(k, g);
          add_exp(k, 8'h40 + 8'(k), 1'b1, g);
          g = 1;
        end
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("first_grant", bus.grant, gtab[v].g);
      wait_drain(60, "grant_tab_drain");
    end

    // Flush in IDLE is the OR of all requests
    for (int v = 0; v < 5; v++) begin
      flush_drv = ftab[v].f;
      @(posedge clk);
      @(negedge clk);
      chk("idle_flush", bus.in_flush_now, ftab[v].e);
    end
    flush_drv = '0;

    // Two 3-byte packets: 0,0,0,bubble,1,1,1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_src(0, 8'h10 + 8'(i), i == 2, 0);
      add_src(1, 8'h20 + 8'(i), i == 2, 0);
    end
    g = -1; exp_grant(0, g);
    for (int i = 0; i < 3; i++) add_exp(0, 8'h10 + 8'(i), i == 2, (i == 0) ? g : 0);
    g = 1; exp_grant(1, g);
    for (int i = 0; i < 3; i++) add_exp(1, 8'h20 + 8'(i), i == 2, (i == 0) ? g : 0);
    wait_drain(60, "pkt3_drain");

    // MAX_BURST split: 64 bytes, bubble, port 1, bubble, remaining 36
    do_reset();
    for (int i = 0; i < 100; i++) add_src(0, 8'(i), i == 99, 0);
    add_src(1, 8'h90, 1'b0, 0);
    add_src(1, 8'h91, 1'b1, 0);
    g = -1; exp_grant(0, g);
    for (int i = 0; i < 64; i++) add_exp(0, 8'(i), 1'b0, (i == 0) ? g : 0);
    g = 1; exp_grant(1, g);
    add_exp(1, 8'h90, 1'b0, g);
    add_exp(1, 8'h91, 1'b1, 0);
    g = 1; exp_grant(0, g);
    for (int i = 64; i < 100; i++) add_exp(0, 8'(i), i == 99, (i == 64) ? g : 0);
    wait_drain(300, "burst_drain");

    // Valid low for IDLE_TO-1 cycles keeps the grant
    do_reset();
    add_src(0, 8'h30, 1'b0, 0);
    add_src(0, 8'h31, 1'b1, ITO - 1);
    add_src(1, 8'h38, 1'b1, 0);
    g = -1; exp_grant(0, g);
    add_exp(0, 8'h30, 1'b0, g);
    add_exp(0, 8'h31, 1'b1, ITO - 1);
    g = 1; exp_grant(1, g);
    add_exp(1, 8'h38, 1'b1, g);
    wait_drain(100, "stall15_drain");

    // Valid low for IDLE_TO cycles releases; waiting port 1 goes first
    do_reset();
    add_src(0, 8'h30, 1'b0, 0);
    add_src(0, 8'h31, 1'b1, ITO);
    add_src(1, 8'h38, 1'b1, 0);
    g = -1; exp_grant(0, g);
    add_exp(0, 8'h30, 1'b0, g);
    g = ITO + 1; exp_grant(1, g);
    add_exp(1, 8'h38, 1'b1, g);
    g = 1; exp_grant(0, g);
    add_exp(0, 8'h31, 1'b1, g);
    wait_drain(100, "stall16_drain");

    // in_ready toggling during a 5-byte packet
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 5; i++) add_src(0, 8'h60 + 8'(i), i == 4, 0);
    g = -1; exp_grant(0, g);
    for (int i = 0; i < 5; i++) add_exp(0, 8'h60 + 8'(i), i == 4, -1);
    wait_drain(60, "toggle_drain");
    ready_mode = 0;

    // Flush while busy follows the granted port only
    do_reset();
    add_src(0, 8'h70, 1'b0, 0);
    add_src(0, 8'h71, 1'b1, 10);
    g = -1; exp_grant(0, g);
    add_exp(0, 8'h70, 1'b0, g);
    add_exp(0, 8'h71, 1'b1, 10);
    repeat (4) @(posedge clk);
    flush_drv = 3'b010;
    @(negedge clk);
    chk("busy_flush_other", bus.in_flush_now, 0);
    @(posedge clk);
    flush_drv = 3'b001;
    @(negedge clk);
    chk("busy_flush_owner", bus.in_flush_now, 1);
    flush_drv = '0;
    wait_drain(60, "flush_drain");

    // Port 2 single byte with last
    do_reset();
    add_src(2, 8'h55, 1'b1, 0);
    g = -1; exp_grant(2, g);
    add_exp(2, 8'h55, 1'b1, g);
    wait_drain(30, "port2_drain");

    // Reset mid-burst, then port 0 wins first contention
    do_reset();
    for (int i = 0; i < 20; i++) add_src(0, 8'(i), 1'b0, 0);
    add_src(1, 8'h21, 1'b1, 0);
    g = -1; exp_grant(0, g);
    for (int i = 0; i < 20; i++) add_exp(0, 8'(i), 1'b0, (i == 0) ? g : 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int k = 0; k < N; k++) srcq[k].delete();
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add_src(0, 8'h11, 1'b1, 0);
    add_src(1, 8'h21, 1'b1, 0);
    g = -1; exp_grant(0, g);
    add_exp(0, 8'h11, 1'b1, g);
    g = 1; exp_grant(1, g);
    add_exp(1, 8'h21, 1'b1, g);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_grant", bus.grant, 3'b001);
    wait_drain(60, "post_reset_drain");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muacm_in_arb.md
# muacm_in_arb

Packet-atomic round-robin arbiter sharing the single `muacm` IN (device-to-host) byte stream between `N_PORTS` requesters. Sits between user logic and the `muacm` core and drives its `in_*` data, last and flush inputs. Grant is held from first byte to `last`, a byte-count limit, or a stall timeout, so short packets from different sources are not interleaved. Optional per-burst tag byte lets the host demultiplex sources.

## Interface

- `N_PORTS`, 2: number of requesters, 2..8.
- `MAX_BURST`, 64: bytes per grant before forced re-arbitration, 1..255.
- `IDLE_TO`, 16: cycles the granted port may hold `valid` low before grant is released, 1..255.
- `clk`  in  1  system clock, single domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_data`  in  8*N_PORTS  byte per port, port k at [8k+7:8k].
- `req_last`  in  N_PORTS  end-of-packet per port.
- `req_valid`  in  N_PORTS  byte valid per port.
- `req_ready`  out  N_PORTS  byte accepted per port.
- `req_flush`  in  N_PORTS  flush-now request per port.
- `in_data`  out  8  to muacm `in_data`.
- `in_last`  out  1  to muacm `in_last`.
- `in_valid`  out  1  to muacm `in_valid`.
- `in_ready`  in  1  from muacm `in_ready`.
- `in_flush_now`  out  1  to muacm `in_flush_now`.
- `in_flush_time`  out  1  to muacm `in_flush_time`, constant 1.
- `grant`  out  N_PORTS  one-hot current owner, 0 when idle.

## Operation

- States: IDLE, TAG (only with tag feature), DATA.
- IDLE: pick first port with `req_valid` set, searching from `rr_ptr` upward with wrap; register `grant`, go to DATA (TAG if enabled). No valid -> stay.
- DATA: `in_data/in_last/in_valid` = granted port's signals; `req_ready[g]` = `in_ready`; other `req_ready` = 0. Transfer = `in_valid & in_ready`.
- Burst counter (8 bit) cleared on grant, +1 per transfer.
- Release to IDLE when a transfer has `in_last`, or counter reaches `MAX_BURST` on a transfer, or stall counter reaches `IDLE_TO`. Simultaneous conditions -> single release. On release `rr_ptr` = granted index + 1 mod N_PORTS, `grant` = 0.
- Stall counter: cleared on grant and on any cycle with granted `req_valid` high; +1 otherwise.
- `last` is never synthesised; forced release splits a packet without marking it.
- `in_flush_now` = `req_flush[g]` in DATA/TAG; in IDLE = OR of all `req_flush`. Flush requests from non-granted ports while busy are dropped (level, requester holds it).
- `in_data` = 0, `in_last` = 0 whenever `in_valid` = 0.

## Timing

- Reset: state IDLE, `grant` 0, `rr_ptr` 0, counters 0, `in_valid` 0, `req_ready` 0, `in_flush_now` 0, `in_last` 0, `in_data` 0.
- Grant decision registered: first byte presented on `in_*` one cycle after `req_valid` rises in IDLE.
- DATA path combinational: zero-latency valid/ready/data pass-through.
- After release exactly one IDLE bubble cycle before next grant, including same port re-grant.
- Reset asserted mid-burst: immediate return to reset values; in-flight byte is lost.

## Configuration

- `MUACM_ARB_TAG_EN` defined: on each grant enter TAG, present `in_data` = 8'hA0 | port index, `in_last` 0, `in_valid` 1; on `in_ready` go to DATA. Tag byte not counted in burst or stall counters; `req_ready` all 0 during TAG.
- Undefined: TAG state absent, IDLE goes directly to DATA; no header bytes.

## Structure

- `muacm_arb_pkg`: state encoding, `TAG_BASE` = 8'hA0, counter width constant.
- Sub-module `muacm_arb_rr`: combinational rotate-priority picker (`req`, `ptr` -> one-hot, index, `any`).

## Test plan

- Ports 0 and 1 both send 3-byte packets (last on 3rd), `in_ready` 1 -> stream 0,0,0,bubble,1,1,1; `grant` 01 then 10.
- Port 0 streams 100 bytes no last, port 1 waiting, MAX_BURST 64 -> 64 bytes of port 0, bubble, port 1 granted.
- Granted port drops valid for 16 cycles, IDLE_TO 16 -> grant 0 next cycle, other waiting port granted after.
- `in_ready` toggling 1/0 each cycle during 5-byte packet -> no byte lost or duplicated, `req_ready` mirrors `in_ready`.
- With `MUACM_ARB_TAG_EN`, port 2 sends 0x55 with last -> `in_data` 0xA2 then 0x55 with `in_last` 1.
- `rst_n` low mid-burst -> all outputs 0 asynchronously; after release port 0 wins first contention.
